lb2drp_arbiter: RTL

//  Shares one DRP port between two local-bus requesters (S0, S1) using round-robin arbitration.

---
 rtl/lb2drp_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/lb2drp_arbiter.sv
// Round-robin arbiter that shares one DRP port between two local-bus requesters.
// Optional macro DRP_TIMEOUT_EN adds a WAIT-state abort after C_TIMEOUT cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transaction in flight; pick a pending slot (round robin)
// ST_ISSUE | one-cycle DRP enable for the granted slot
// ST_WAIT  | wait for M_DRPRDY (or timeout abort), then retire the slot
module lb2drp_arbiter #(
    parameter int C_ADDR_WIDTH = 12,
    parameter int C_DATA_WIDTH = 16
`ifdef DRP_TIMEOUT_EN
    ,
    parameter int C_TIMEOUT    = 1023
`endif
) (
    input  logic                    CLK_I,
    input  logic                    RSTN_I,
    input  logic [C_ADDR_WIDTH-1:0] S0_LB_WADDR,
    input  logic [C_DATA_WIDTH-1:0] S0_LB_WDATA,
    input  logic                    S0_LB_WREQ,
    input  logic [C_ADDR_WIDTH-1:0] S0_LB_RADDR,
    input  logic                    S0_LB_RREQ,
    output logic [C_DATA_WIDTH-1:0] S0_LB_RDATA,
    output logic                    S0_LB_RFINISH,
    output logic                    S0_LB_BUSY,
    input  logic [C_ADDR_WIDTH-1:0] S1_LB_WADDR,
    input  logic [C_DATA_WIDTH-1:0] S1_LB_WDATA,
    input  logic                    S1_LB_WREQ,
    input  logic [C_ADDR_WIDTH-1:0] S1_LB_RADDR,
    input  logic                    S1_LB_RREQ,
    output logic [C_DATA_WIDTH-1:0] S1_LB_RDATA,
    output logic                    S1_LB_RFINISH,
    output logic                    S1_LB_BUSY,
    output logic                    M_DRPEN,
    output logic                    M_DRPWE,
    output logic [C_ADDR_WIDTH-1:0] M_DRPADDR,
    output logic [C_DATA_WIDTH-1:0] M_DRPDI,
    input  logic [C_DATA_WIDTH-1:0] M_DRPDO,
    input  logic                    M_DRPRDY,
    output logic                    S_DRP_TIMEOUT
);

    localparam int AW = C_ADDR_WIDTH;
    localparam int DW = C_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   grant, grant_nxt;
    logic   rr_ptr, rr_nxt;
    logic   load, done, abort;

    logic [1:0]    wreq, rreq;
    logic [AW-1:0] waddr [2];
    logic [AW-1:0] raddr [2];
    logic [DW-1:0] wdata [2];

    logic [1:0]    slot_pend, slot_wr;
    logic [AW-1:0] slot_addr [2];
    logic [DW-1:0] slot_data [2];

    logic [DW-1:0] rdata [2];
    logic [1:0]    rfinish;
    logic [AW-1:0] drp_addr;
    logic [DW-1:0] drp_di;

    assign wreq     = {S1_LB_WREQ, S0_LB_WREQ};
    assign rreq     = {S1_LB_RREQ, S0_LB_RREQ};
    assign waddr[0] = S0_LB_WADDR;
    assign waddr[1] = S1_LB_WADDR;
    assign raddr[0] = S0_LB_RADDR;
    assign raddr[1] = S1_LB_RADDR;
    assign wdata[0] = S0_LB_WDATA;
    assign wdata[1] = S1_LB_WDATA;

`ifdef DRP_TIMEOUT_EN
    localparam int CNT_W = (C_TIMEOUT > 2) ? $clog2(C_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             drp_timeout;

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            wait_cnt    <= '0;
            drp_timeout <= 1'b0;
        end else begin
            drp_timeout <= abort;
            if (state != ST_WAIT)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign S_DRP_TIMEOUT = drp_timeout;
`else
    assign S_DRP_TIMEOUT = 1'b0;
`endif

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            state  <= ST_IDLE;
            grant  <= 1'b0;
            rr_ptr <= 1'b0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        rr_nxt    = rr_ptr;
        load      = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                // pointer only advances when both slots contend
                if (&slot_pend) begin
                    grant_nxt = rr_ptr;
                    rr_nxt    = ~rr_ptr;
                    load      = 1'b1;
                    state_nxt = ST_ISSUE;
                end else if (|slot_pend) begin
                    grant_nxt = slot_pend[1];
                    load      = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (M_DRPRDY) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
`ifdef DRP_TIMEOUT_EN
                else if (wait_cnt == CNT_LAST) begin
                    abort     = 1'b1;
                    state_nxt = ST_IDLE;
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            slot_pend <= '0;
            slot_wr   <= '0;
            rfinish   <= '0;
            drp_addr  <= '0;
            drp_di    <= '0;
            for (int n = 0; n < 2; n++) begin
                slot_addr[n] <= '0;
                slot_data[n] <= '0;
                rdata[n]     <= '0;
            end
        end else begin
            rfinish <= '0;
            for (int n = 0; n < 2; n++) begin
                // write wins when both pulses arrive together; busy slots ignore requests
                if (!slot_pend[n]) begin
                    if (wreq[n]) begin
                        slot_pend[n] <= 1'b1;
                        slot_wr[n]   <= 1'b1;
                        slot_addr[n] <= waddr[n];
                        slot_data[n] <= wdata[n];
                    end else if (rreq[n]) begin
                        slot_pend[n] <= 1'b1;
                        slot_wr[n]   <= 1'b0;
                        slot_addr[n] <= raddr[n];
                        slot_data[n] <= '0;
                    end
                end else if ((done || abort) && (grant == 1'(n))) begin
                    slot_pend[n] <= 1'b0;
                end
            end
            if (load) begin
                drp_addr <= slot_addr[grant_nxt];
                drp_di   <= slot_data[grant_nxt];
            end
            if ((done || abort) && !slot_wr[grant]) begin
                rdata[grant]   <= done ? M_DRPDO : '1;
                rfinish[grant] <= 1'b1;
            end
        end
    end

    assign M_DRPEN       = (state == ST_ISSUE);
    assign M_DRPWE       = M_DRPEN & slot_wr[grant];
    assign M_DRPADDR     = drp_addr;
    assign M_DRPDI       = drp_di;
    assign S0_LB_BUSY    = slot_pend[0];
    assign S1_LB_BUSY    = slot_pend[1];
    assign S0_LB_RDATA   = rdata[0];
    assign S1_LB_RDATA   = rdata[1];
    assign S0_LB_RFINISH = rfinish[0];
    assign S1_LB_RFINISH = rfinish[1];

endmodule
